fifo_pkt_writer: RTL and testbench
==================================

Name: fifo_pkt_writer

Overview:
- Write-side producer for the dual-clock FIFO RAM, in the clk_a domain.
- Accepts a valid/ready word stream with end-of-packet marker from upstream logic.
- Writes the data words into the FIFO through din_a/wen_a and honours full as backpressure.
- Appends a two-word trailer to every packet: word count with truncation flag, then XOR checksum. This lets the read-side consumer frame and check each packet.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the FIFO; minimum 16.
- MAX_LEN, 1024, maximum data words per packet; must be less than 2^(FIFO_WIDTH-1).

Ports:
- clk_a  input  1  write-domain clock
- rst  input  1  reset
- s_data  input  FIFO_WIDTH  upstream data word
- s_valid  input  1  upstream word valid
- s_last  input  1  current word is the last of its packet
- s_ready  output  1  block accepts s_data this cycle
- full  input  1  FIFO full flag, treated as synchronous to clk_a
- din_a  output  FIFO_WIDTH  FIFO write data
- wen_a  output  1  FIFO write enable
- pkt_done  output  1  one-cycle pulse when the second trailer word is written
- pkt_count  output  16  packets completed since reset; wraps at 0xFFFF
- busy  output  1  high whenever state is not IDLE

Interface decision: reset rst, synchronous, active-high; clock clk_a.

Behaviour:
- Reset (rst high at the clk_a edge):
  - state to IDLE; word counter, checksum and pkt_count to 0; pkt_done to 0.
  - s_ready, wen_a and busy are forced to 0 combinationally while rst is high.
  - din_a is 0 during reset.
- Reset mid-packet abandons the packet. Words already in the FIFO stay there; no trailer is written.
- States: IDLE, DATA, TRL_CNT, TRL_CHK.
- Handshake:
  - A transfer occurs on a cycle where s_valid and s_ready are both high.
  - s_ready = !rst && !full && (state is IDLE or DATA).
  - s_ready never depends on s_valid.
- Write path is zero-latency, because the FIFO drops writes when full and a registered enable would lose data:
  - wen_a = transfer, or (state is TRL_CNT or TRL_CHK, and !full, and !rst).
  - din_a = s_data in IDLE/DATA, the count word in TRL_CNT, the checksum in TRL_CHK.
- Word counter wc (width ceil(log2(MAX_LEN+1))) and checksum ck (FIFO_WIDTH):
  - On a transfer in IDLE: wc becomes 1 and ck becomes s_data.
  - On a transfer in DATA: wc increments and ck becomes ck XOR s_data.
- Transitions:
  - IDLE: a transfer with s_last, or with MAX_LEN equal to 1, goes to TRL_CNT. Any other transfer goes to DATA. No transfer stays in IDLE.
  - DATA: a transfer with s_last goes to TRL_CNT. A transfer where the updated wc equals MAX_LEN also goes to TRL_CNT and sets the trunc flag.
  - TRL_CNT: when wen_a is high, go to TRL_CHK.
  - TRL_CHK: when wen_a is high, go to IDLE, pulse pkt_done on the next cycle, and increment pkt_count.
- Count word layout: bit FIFO_WIDTH-1 is trunc; the low bits hold wc zero-extended.
  - trunc is set only when MAX_LEN words are reached with s_last low on the final word.
  - If s_last is high on the MAX_LEN-th word, trunc is 0.
- After a truncated packet, later upstream words form a new packet starting in IDLE.
- full asserted in any state stalls the block: no write occurs, state holds, counters hold. Resumption is seamless when full deasserts.
- s_last is ignored on cycles without a transfer.
- Back-to-back packets:
  - The trailer costs two write cycles, during which s_ready is 0.
  - Minimum packet cost is data words plus 2 cycles.
  - The first word of the next packet can transfer on the cycle after TRL_CHK is written.
- pkt_done is registered: high exactly one cycle, one cycle after the second trailer write.

Test Plan:
- Reset: hold rst 2 cycles with s_valid=1 and full=0 → s_ready=0, wen_a=0, busy=0 throughout; after release pkt_count=0 and s_ready=1.
- Basic packet: stream 0x1111, 0x2222, 0x4444 (last on the third), full=0 → FIFO receives 0x1111, 0x2222, 0x4444, 0x0003, 0x7777 on 5 consecutive cycles; pkt_done pulses once; pkt_count=1.
- Backpressure: same packet with full held high for 3 cycles while in DATA, then again for 2 cycles in TRL_CNT → no word lost or duplicated; the FIFO sequence is identical to the basic case; s_ready=0 whenever full=1.
- Truncation: MAX_LEN=4, stream 6 words 0x0001..0x0006 with s_last only on the sixth word → FIFO gets:
  - 0x0001..0x0004, then 0x8004, then 0x0004;
  - then 0x0005, 0x0006, then 0x0002, then 0x0003;
  - pkt_count=2.
- Single-word and back-to-back packets: 0xABCD (last), then immediately 0x0F0F (last) → FIFO gets 0xABCD, 0x0001, 0xABCD, 0x0F0F, 0x0001, 0x0F0F; s_ready is low only during the trailer cycles.
- Reset mid-packet: assert rst after 2 of 4 words are accepted → no trailer is written; state is IDLE; the next packet's count word starts from 1.

Source files
------------

// File: rtl/fifo_pkt_writer.sv
// Write-side packet producer for the dual-clock FIFO (clk_a domain).
// Forwards upstream words into the FIFO with zero latency. After each packet it
// appends two trailer words: {trunc, word count}, then the XOR checksum.
//
// state   | meaning
// IDLE    | waiting for the first word of a packet
// DATA    | packet in progress, accepting further words
// TRL_CNT | writing the count word (trunc flag in the MSB)
// TRL_CHK | writing the XOR checksum word
module fifo_pkt_writer #(
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_LEN    = 1024
) (
    input  logic                  clk_a,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  full,
    output logic [FIFO_WIDTH-1:0] din_a,
    output logic                  wen_a,
    output logic                  pkt_done,
    output logic [15:0]           pkt_count,
    output logic                  busy
);

    localparam int WC_W = $clog2(MAX_LEN + 1);
    localparam logic [WC_W-1:0] MAX_WC = WC_W'(MAX_LEN);
    localparam logic [WC_W-1:0] ONE_WC = WC_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        TRL_CNT = 2'd2,
        TRL_CHK = 2'd3
    } state_t;

    state_t                state;
    logic [WC_W-1:0]       wc;
    logic [FIFO_WIDTH-1:0] ck;
    logic                  trunc;

    logic                  accepting;
    logic                  in_trailer;
    logic                  xfer;
    logic [WC_W-1:0]       wc_inc;
    logic [FIFO_WIDTH-1:0] cnt_word;

    // Handshake and write strobe are combinational so a word is never lost
    // when full rises: the FIFO sees the write in the same cycle it is accepted.
    always_comb begin
        accepting  = (state == IDLE) || (state == DATA);
        in_trailer = (state == TRL_CNT) || (state == TRL_CHK);
        s_ready    = !rst && !full && accepting;
        xfer       = s_valid && s_ready;
        wen_a      = xfer || (in_trailer && !full && !rst);
        busy       = !rst && (state != IDLE);
        wc_inc     = wc + ONE_WC;
    end

    // Count word: trunc flag in the MSB, word count zero-extended below it.
    always_comb begin
        cnt_word                 = '0;
        cnt_word[WC_W-1:0]       = wc;
        cnt_word[FIFO_WIDTH-1]   = trunc;
    end

    // Write data mux: pass-through while accepting data, trailer words otherwise.
    always_comb begin
        din_a = '0;
        if (!rst) begin
            case (state)
                TRL_CNT: din_a = cnt_word;
                TRL_CHK: din_a = ck;
                default: din_a = s_data;
            endcase
        end
    end

    // Packet sequencer: word count, checksum, trailer emission and completion stats.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state     <= IDLE;
            wc        <= '0;
            ck        <= '0;
            trunc     <= 1'b0;
            pkt_count <= 16'd0;
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        wc    <= ONE_WC;
                        ck    <= s_data;
                        trunc <= (MAX_LEN == 1) && !s_last;
                        if (s_last || (MAX_LEN == 1))
                            state <= TRL_CNT;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wc <= wc_inc;
                        ck <= ck ^ s_data;
                        if (s_last) begin
                            trunc <= 1'b0;
                            state <= TRL_CNT;
                        end else if (wc_inc == MAX_WC) begin
                            trunc <= 1'b1;
                            state <= TRL_CNT;
                        end
                    end
                end
                TRL_CNT: begin
                    if (wen_a)
                        state <= TRL_CHK;
                end
                TRL_CHK: begin
                    if (wen_a) begin
                        state     <= IDLE;
                        pkt_done  <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench for fifo_pkt_writer (MAX_LEN=4 so truncation is reachable).
module tb_fifo_pkt_writer;

    logic        clk_a = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        full;
    logic [15:0] din_a;
    logic        wen_a;
    logic        pkt_done;
    logic [15:0] pkt_count;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] vw[16];
    logic        vl[16];

    fifo_pkt_writer #(.FIFO_WIDTH(16), .MAX_LEN(4)) dut (
        .clk_a     (clk_a),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .full      (full),
        .din_a     (din_a),
        .wen_a     (wen_a),
        .pkt_done  (pkt_done),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 clk_a = ~clk_a;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every FIFO write must match the next expected word.
    always @(negedge clk_a) begin
        if (pkt_done === 1'b1) done_seen++;
        if (wen_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", din_a, $time);
            end else begin
                chk("fifo_word", {16'd0, din_a}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    // Stream vw/vl continuously; each cycle check s_ready against the pattern
    // and that a FIFO write happens (full is held low).
    task automatic stream(input int nw, input int ncyc, input logic [31:0] rdy_pat);
        int idx = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (idx < nw) begin
                s_valid = 1'b1; s_data = vw[idx]; s_last = vl[idx];
            end else begin
                s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0;
            end
            @(negedge clk_a);
            chk("s_ready", {31'd0, s_ready}, {31'd0, rdy_pat[c]});
            chk("wen_a", {31'd0, wen_a}, 32'd1);
            if (s_valid && s_ready) idx++;
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b0; full = 1'b0;

        // Reset with valid asserted: nothing may be accepted or written.
        repeat (2) begin
            @(negedge clk_a);
            chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
            chk("rst_wen_a", {31'd0, wen_a}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            step();
        end
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk_a);
        chk("post_rst_count", {16'd0, pkt_count}, 32'd0);
        chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        step();

        // Basic packet: 3 words + 2 trailer words on 5 consecutive cycles.
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h4444);
        exp_q.push_back(16'h0003); exp_q.push_back(16'h7777);
        vw[0] = 16'h1111; vl[0] = 1'b0;
        vw[1] = 16'h2222; vl[1] = 1'b0;
        vw[2] = 16'h4444; vl[2] = 1'b1;
        stream(3, 5, 32'b00111);
        chk("basic_done", {31'd0, pkt_done}, 32'd1);
        chk("basic_count", {16'd0, pkt_count}, 32'd1);
        step();
        chk("basic_done_low", {31'd0, pkt_done}, 32'd0);

        // Backpressure in DATA (3 cycles) and in TRL_CNT (2 cycles).
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h4444);
        exp_q.push_back(16'h0003); exp_q.push_back(16'h7777);
        s_valid = 1'b1; s_data = 16'h1111; s_last = 1'b0; full = 1'b0;
        step();
        s_data = 16'h2222; full = 1'b1;
        repeat (3) begin
            @(negedge clk_a);
            chk("bp_data_ready", {31'd0, s_ready}, 32'd0);
            chk("bp_data_wen", {31'd0, wen_a}, 32'd0);
            step();
        end
        full = 1'b0;
        step();
        s_data = 16'h4444; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0; full = 1'b1;
        repeat (2) begin
            @(negedge clk_a);
            chk("bp_trl_ready", {31'd0, s_ready}, 32'd0);
            chk("bp_trl_wen", {31'd0, wen_a}, 32'd0);
            chk("bp_trl_busy", {31'd0, busy}, 32'd1);
            step();
        end
        full = 1'b0;
        step();
        step();
        chk("bp_done", {31'd0, pkt_done}, 32'd1);
        chk("bp_count", {16'd0, pkt_count}, 32'd2);
        step();

        // Truncation at MAX_LEN=4; remaining words form a second packet.
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i + 1));
        exp_q.push_back(16'h8004); exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0005); exp_q.push_back(16'h0006);
        exp_q.push_back(16'h0002); exp_q.push_back(16'h0003);
        for (int i = 0; i < 6; i++) begin
            vw[i] = 16'(i + 1);
            vl[i] = (i == 5);
        end
        stream(6, 10, 32'b0011001111);
        chk("trunc_done", {31'd0, pkt_done}, 32'd1);
        chk("trunc_count", {16'd0, pkt_count}, 32'd4);
        step();

        // Single-word packets back to back.
        exp_q.push_back(16'hABCD); exp_q.push_back(16'h0001); exp_q.push_back(16'hABCD);
        exp_q.push_back(16'h0F0F); exp_q.push_back(16'h0001); exp_q.push_back(16'h0F0F);
        vw[0] = 16'hABCD; vl[0] = 1'b1;
        vw[1] = 16'h0F0F; vl[1] = 1'b1;
        stream(2, 6, 32'b001001);
        chk("b2b_count", {16'd0, pkt_count}, 32'd6);
        step();

        // Reset after 2 of 4 words: no trailer, state back to IDLE.
        exp_q.push_back(16'h0A0A); exp_q.push_back(16'h0B0B);
        vw[0] = 16'h0A0A; vl[0] = 1'b0;
        vw[1] = 16'h0B0B; vl[1] = 1'b0;
        stream(2, 2, 32'b11);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; s_valid = 1'b1; s_data = 16'h0C0C;
        @(negedge clk_a);
        chk("mid_rst_wen", {31'd0, wen_a}, 32'd0);
        step();
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk_a);
        chk("mid_idle", {31'd0, busy}, 32'd0);
        chk("mid_count", {16'd0, pkt_count}, 32'd0);
        step();
        step();
        exp_q.push_back(16'h0055); exp_q.push_back(16'h0001); exp_q.push_back(16'h0055);
        vw[0] = 16'h0055; vl[0] = 1'b1;
        stream(1, 3, 32'b001);
        chk("final_count", {16'd0, pkt_count}, 32'd1);
        step();
        step();

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                step();
                guard++;
            end
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_pulses", 32'(done_seen), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
